// File: rtl/mem_stage_pkg.sv
// Shared encodings for the RV32 memory-access stage: access sizes, FSM states
// and the alignment rule used by both the store and load paths.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // The illegal size encoding is reported the same way as a misaligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF:    bad = addr_lo[0];
            SIZE_WORD:    bad = |addr_lo;
            SIZE_ILLEGAL: bad = 1'b1;
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for a 32-bit data port: store lane steering,
// load extraction/extension and misalignment detection.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  sign,
    input  logic [31:0]           st_data,
    input  logic [31:0]           rdata,
    output logic [BYTE_LANES-1:0] be,
    output logic [31:0]           wdata,
    output logic [31:0]           ld_data,
    output logic                  misalign
);

    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign misalign = is_misaligned(size, addr_lo);

    // Replicating the data across lanes lets memory pick any lane via be.
    always_comb begin
        be    = '0;
        wdata = st_data;
        case (size)
            SIZE_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = '0;
        endcase
    end

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = shifted[15:0];

    always_comb begin
        ld_data = rdata;
        case (size)
            SIZE_BYTE: ld_data = {{24{sign & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{sign & ld_half[15]}}, ld_half};
            default:   ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: captures an EX instruction, runs the data-memory req/rsp
// handshake and emits one registered writeback beat (also the MEM forward source).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  result,
    input  logic [WORD_SIZE-1:0]  save_data,
    input  logic [REG_SEL-1:0]    rd,
    input  logic [1:0]            data_size,
    input  logic                  data_sign,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_SIZE-1:0]  dmem_addr,
    output logic [WORD_SIZE-1:0]  dmem_wdata,
    output logic [BYTE_LANES-1:0] dmem_be,
    input  logic                  dmem_ready,
    input  logic                  dmem_rvalid,
    input  logic [WORD_SIZE-1:0]  dmem_rdata,
    output logic                  wb_valid,
    output logic [WORD_SIZE-1:0]  wb_data,
    output logic [REG_SEL-1:0]    wb_rd,
    output logic                  wb_reg_write,
    output logic                  misalign_err
);

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [REG_SEL-1:0]   rd;
        logic [1:0]           size;
        logic                 sign;
        logic                 is_load;
        logic                 reg_write;
    } mem_req_t;

    state_t   state, state_nxt;
    mem_req_t req_q, req_nxt;

    logic                  wb_valid_nxt, wb_we_nxt, mis_nxt;
    logic [WORD_SIZE-1:0]  wb_data_nxt;
    logic [REG_SEL-1:0]    wb_rd_nxt;
    logic                  dmem_req_nxt, dmem_we_nxt;
    logic [ADDR_SIZE-1:0]  dmem_addr_nxt;
    logic [WORD_SIZE-1:0]  dmem_wdata_nxt;
    logic [BYTE_LANES-1:0] dmem_be_nxt;

    logic [1:0]            al_addr_lo, al_size;
    logic                  al_sign, al_misalign;
    logic [BYTE_LANES-1:0] al_be;
    logic [WORD_SIZE-1:0]  al_wdata, al_ld_data;

    assign in_ready = (state == ST_IDLE);

    // IDLE steers the live EX inputs (store lanes, misalign); later states
    // steer the captured request so the load extract uses the original address.
    assign al_addr_lo = in_ready ? result[1:0] : req_q.addr[1:0];
    assign al_size    = in_ready ? data_size   : req_q.size;
    assign al_sign    = in_ready ? data_sign   : req_q.sign;

    mem_align u_align (
        .addr_lo  (al_addr_lo),
        .size     (al_size),
        .sign     (al_sign),
        .st_data  (save_data),
        .rdata    (dmem_rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .ld_data  (al_ld_data),
        .misalign (al_misalign)
    );

    always_comb begin
        state_nxt      = state;
        req_nxt        = req_q;
        wb_valid_nxt   = 1'b0;
        wb_we_nxt      = 1'b0;
        mis_nxt        = 1'b0;
        wb_data_nxt    = wb_data;
        wb_rd_nxt      = wb_rd;
        dmem_req_nxt   = dmem_req;
        dmem_we_nxt    = dmem_we;
        dmem_addr_nxt  = dmem_addr;
        dmem_wdata_nxt = dmem_wdata;
        dmem_be_nxt    = dmem_be;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    wb_rd_nxt   = rd;
                    wb_data_nxt = result;
                    if (!(mem_read || mem_write)) begin
                        wb_valid_nxt = 1'b1;
                        wb_we_nxt    = reg_write && (rd != '0);
                    end else if (al_misalign) begin
                        // Faulting access retires as a no-write beat.
                        wb_valid_nxt = 1'b1;
                        mis_nxt      = 1'b1;
                    end else begin
                        state_nxt         = ST_REQ;
                        req_nxt.addr      = result[ADDR_SIZE-1:0];
                        req_nxt.rd        = rd;
                        req_nxt.size      = data_size;
                        req_nxt.sign      = data_sign;
                        req_nxt.is_load   = !mem_write;
                        req_nxt.reg_write = reg_write;
                        dmem_req_nxt      = 1'b1;
                        dmem_we_nxt       = mem_write;
                        dmem_addr_nxt     = {result[ADDR_SIZE-1:2], 2'b00};
                        dmem_wdata_nxt    = al_wdata;
                        dmem_be_nxt       = al_be;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ready) begin
                    dmem_req_nxt = 1'b0;
                    if (req_q.is_load) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt    = ST_IDLE;
                        wb_valid_nxt = 1'b1;
                        wb_rd_nxt    = req_q.rd;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_nxt    = ST_IDLE;
                    wb_valid_nxt = 1'b1;
                    wb_data_nxt  = al_ld_data;
                    wb_rd_nxt    = req_q.rd;
                    wb_we_nxt    = req_q.reg_write && (req_q.rd != '0);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            misalign_err <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
        end else begin
            state        <= state_nxt;
            req_q        <= req_nxt;
            wb_valid     <= wb_valid_nxt;
            wb_data      <= wb_data_nxt;
            wb_rd        <= wb_rd_nxt;
            wb_reg_write <= wb_we_nxt;
            misalign_err <= mis_nxt;
            dmem_req     <= dmem_req_nxt;
            dmem_we      <= dmem_we_nxt;
            dmem_addr    <= dmem_addr_nxt;
            dmem_wdata   <= dmem_wdata_nxt;
            dmem_be      <= dmem_be_nxt;
        end
    end

endmodule
